// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM command arbiter: state encoding,
// default timing parameters and the address width.
package psram_pkg;

    localparam int ADDR_W          = 21;
    localparam int TCMD_DEF        = 19;
    localparam int BURST_BEATS_DEF = 4;
    localparam int RD_TIMEOUT_DEF  = 64;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_WR_BURST = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

endpackage

// File: rtl/psram_rr_arb2.sv
// Two-way round-robin grant. Bit 0 is the read port, bit 1 the write port.
// On a tie the port that was not granted last wins; after reset the
// pointer says "write last", so read wins the first tie.
module psram_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic r_last_wr;

    // Combinational grant: single requester passes through, tie uses pointer.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_last_wr ? 2'b01 : 2'b10;
        end
    end

    // Remember which port won when the grant is actually taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_wr <= 1'b1;
        end else if (update) begin
            r_last_wr <= grant[1];
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// Arbitrates one write requester and one read requester onto a single
// PSRAM command port. Grants happen only in IDLE; every command is
// followed by a GAP so successive cmd_en pulses are at least TCMD apart.
// Handshake: a requester raises *_req and holds it; the arbiter answers
// with a one-cycle *_ack in the grant cycle, after which the request may
// drop. Read beats are returned one cycle after mem_rd_valid.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int TCMD        = TCMD_DEF,
    parameter int BURST_BEATS = BURST_BEATS_DEF,
    parameter int RD_TIMEOUT  = RD_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_calib,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [63:0]       wr_data,
    input  logic [7:0]        wr_mask,
    output logic              wr_ack,
    output logic              wr_beat,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [63:0]       rd_data,
    output logic [1:0]        rd_beat_idx,
    output logic              err_timeout,
    output logic              mem_cmd,
    output logic              mem_cmd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wr_data,
    output logic [7:0]        mem_data_mask,
    input  logic [63:0]       mem_rd_data,
    input  logic              mem_rd_valid
);

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_cnt;        // cycles since last mem_cmd_en, saturating
    logic [7:0]          r_beat_cnt;   // beats of the current burst
    logic                r_cmd_en;
    logic                r_cmd;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_err;
    logic                r_rd_valid;
    logic [63:0]         r_rd_data;
    logic [1:0]          r_rd_idx;

    logic [1:0]          w_req;
    logic [1:0]          w_grant;
    logic                w_grant_any;
    logic                w_wr_beat;
    logic                w_rd_take;
    logic                w_last_rd;
    logic                w_timeout;

    // Requests are only visible to the arbiter in IDLE with calibration done.
    assign w_req       = (r_state == ST_IDLE && init_calib) ? {wr_req, rd_req} : 2'b00;
    assign w_grant_any = |w_grant;

    psram_rr_arb2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (w_req),
        .update (w_grant_any),
        .grant  (w_grant)
    );

    assign w_wr_beat = (r_state == ST_WR_BURST);
    assign w_rd_take = (r_state == ST_RD_WAIT) && mem_rd_valid;
    assign w_last_rd = w_rd_take && (r_beat_cnt == 8'(BURST_BEATS - 1));
    assign w_timeout = (r_state == ST_RD_WAIT) && !w_last_rd
                       && (r_cnt >= 8'(RD_TIMEOUT - 1));

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:     if (init_calib) w_next = ST_IDLE;
            ST_IDLE: begin
                if (!init_calib)     w_next = ST_INIT;
                else if (w_grant[1]) w_next = ST_WR_BURST;
                else if (w_grant[0]) w_next = ST_RD_WAIT;
            end
            ST_WR_BURST: if (r_beat_cnt == 8'(BURST_BEATS - 1)) w_next = ST_GAP;
            ST_RD_WAIT:  if (w_last_rd || w_timeout) w_next = ST_GAP;
            // Leave GAP so that the next possible cmd_en lands TCMD after the last.
            ST_GAP:      if (r_cnt >= 8'(TCMD - 2)) w_next = ST_IDLE;
            default:     w_next = ST_INIT;
        endcase
    end

    // State, command, counters and read-return registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_cnt      <= '0;
            r_beat_cnt <= '0;
            r_cmd_en   <= 1'b0;
            r_cmd      <= 1'b0;
            r_addr     <= '0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_idx   <= '0;
        end else begin
            r_state    <= w_next;
            r_cmd_en   <= w_grant_any;
            r_rd_valid <= w_rd_take;
            if (w_rd_take) begin
                r_rd_data <= mem_rd_data;
                r_rd_idx  <= r_beat_cnt[1:0];
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_grant_any) begin
                r_cmd      <= w_grant[1];
                r_addr     <= w_grant[1] ? wr_addr : rd_addr;
                r_cnt      <= '0;
                r_beat_cnt <= '0;
            end else begin
                if (r_cnt != 8'hFF) begin
                    r_cnt <= r_cnt + 8'd1;
                end
                if (w_timeout) begin
                    r_beat_cnt <= '0;
                end else if (w_wr_beat || w_rd_take) begin
                    r_beat_cnt <= r_beat_cnt + 8'd1;
                end
            end
        end
    end

    assign wr_ack        = w_grant[1];
    assign rd_ack        = w_grant[0];
    assign wr_beat       = w_wr_beat;
    assign mem_wr_data   = w_wr_beat ? wr_data : 64'd0;
    assign mem_data_mask = w_wr_beat ? wr_mask : 8'hFF;
    assign mem_cmd_en    = r_cmd_en;
    assign mem_cmd       = r_cmd;
    assign mem_addr      = r_addr;
    assign rd_valid      = r_rd_valid;
    assign rd_data       = r_rd_data;
    assign rd_beat_idx   = r_rd_idx;
    assign err_timeout   = r_err;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a small PSRAM read-return model.
module tb_psram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        init_calib;
    logic        wr_req;
    logic [20:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_mask;
    logic        wr_ack;
    logic        wr_beat;
    logic        rd_req;
    logic [20:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic [1:0]  rd_beat_idx;
    logic        err_timeout;
    logic        mem_cmd;
    logic        mem_cmd_en;
    logic [20:0] mem_addr;
    logic [63:0] mem_wr_data;
    logic [7:0]  mem_data_mask;
    logic [63:0] mem_rd_data;
    logic        mem_rd_valid;

    int          n_vec;
    int          n_bad;
    int          model_beats;
    logic [63:0] model_base;

    psram_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_calib    (init_calib),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_mask       (wr_mask),
        .wr_ack        (wr_ack),
        .wr_beat       (wr_beat),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_ack        (rd_ack),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_beat_idx   (rd_beat_idx),
        .err_timeout   (err_timeout),
        .mem_cmd       (mem_cmd),
        .mem_cmd_en    (mem_cmd_en),
        .mem_addr      (mem_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_data_mask (mem_data_mask),
        .mem_rd_data   (mem_rd_data),
        .mem_rd_valid  (mem_rd_valid)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PSRAM read model: after a read cmd_en, return model_beats consecutive
    // beats (model_base + k), the first one in the cycle after cmd_en.
    initial begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = 64'd0;
        forever begin
            @(negedge clk);
            if (mem_cmd_en === 1'b1 && mem_cmd === 1'b0) begin
                for (int k = 0; k < model_beats; k++) begin
                    @(posedge clk); #1;
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = model_base + 64'(k);
                end
                @(posedge clk); #1;
                mem_rd_valid = 1'b0;
                mem_rd_data  = 64'd0;
            end
        end
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic test_reset();
        rst_n = 1'b0; init_calib = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (wr_ack !== 1'b0 || rd_ack !== 1'b0) begin n_bad++; $display("FAIL rst_acks: wr_ack=%b rd_ack=%b expected 0 0", wr_ack, rd_ack); end
        n_vec++; if (wr_beat !== 1'b0) begin n_bad++; $display("FAIL rst_wr_beat: got %b expected 0", wr_beat); end
        n_vec++; if (mem_cmd_en !== 1'b0 || mem_cmd !== 1'b0) begin n_bad++; $display("FAIL rst_cmd: cmd_en=%b cmd=%b expected 0 0", mem_cmd_en, mem_cmd); end
        n_vec++; if (mem_addr !== 21'd0) begin n_bad++; $display("FAIL rst_addr: got %h expected 0", mem_addr); end
        n_vec++; if (mem_wr_data !== 64'd0 || mem_data_mask !== 8'hFF) begin n_bad++; $display("FAIL rst_wdata: data=%h mask=%h expected 0 ff", mem_wr_data, mem_data_mask); end
        n_vec++; if (rd_valid !== 1'b0 || rd_data !== 64'd0 || rd_beat_idx !== 2'd0) begin n_bad++; $display("FAIL rst_rd: v=%b d=%h i=%0d expected 0 0 0", rd_valid, rd_data, rd_beat_idx); end
        n_vec++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b expected 0", err_timeout); end
    endtask

    task automatic test_init_gate();
        int acks;
        acks = 0;
        @(posedge clk); #1;
        rst_n = 1'b1; wr_req = 1'b1; wr_addr = 21'h000010;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_ack === 1'b1) acks++;
        end
        n_vec++; if (acks !== 0) begin n_bad++; $display("FAIL init_hold_acks: got %0d expected 0", acks); end
        @(posedge clk); #1;
        init_calib = 1'b1;
        @(negedge clk);
        n_vec++; if (wr_ack !== 1'b0) begin n_bad++; $display("FAIL init_ack_early: got %b expected 0", wr_ack); end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin n_bad++; $display("FAIL init_ack: wr_ack=%b rd_ack=%b expected 1 0", wr_ack, rd_ack); end
    endtask

    // Continues from the grant cycle left by test_init_gate.
    task automatic test_single_write();
        @(posedge clk); #1;
        wr_req = 1'b0; wr_data = 64'd1; wr_mask = 8'hF0;
        @(negedge clk);
        n_vec++; if (mem_cmd_en !== 1'b1 || mem_cmd !== 1'b1) begin n_bad++; $display("FAIL wr_cmd: cmd_en=%b cmd=%b expected 1 1", mem_cmd_en, mem_cmd); end
        n_vec++; if (mem_addr !== 21'h000010) begin n_bad++; $display("FAIL wr_addr: got %h expected 000010", mem_addr); end
        n_vec++; if (wr_beat !== 1'b1 || mem_wr_data !== 64'd1 || mem_data_mask !== 8'hF0) begin n_bad++; $display("FAIL wr_beat1: beat=%b data=%h mask=%h expected 1 1 f0", wr_beat, mem_wr_data, mem_data_mask); end
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk); #1;
            wr_data = 64'(k); wr_mask = 8'(k);
            @(negedge clk);
            n_vec++; if (wr_beat !== 1'b1 || mem_wr_data !== 64'(k) || mem_data_mask !== 8'(k)) begin n_bad++; $display("FAIL wr_beat%0d: beat=%b data=%h mask=%h expected 1 %0d %0d", k, wr_beat, mem_wr_data, mem_data_mask, k, k); end
            n_vec++; if (mem_cmd_en !== 1'b0) begin n_bad++; $display("FAIL wr_cmd_en_pulse%0d: got %b expected 0", k, mem_cmd_en); end
        end
        @(posedge clk); #1;
        wr_data = 64'd5; wr_mask = 8'h05;
        @(negedge clk);
        n_vec++; if (wr_beat !== 1'b0 || mem_wr_data !== 64'd0 || mem_data_mask !== 8'hFF) begin n_bad++; $display("FAIL wr_end: beat=%b data=%h mask=%h expected 0 0 ff", wr_beat, mem_wr_data, mem_data_mask); end
        repeat (20) @(posedge clk);
    endtask

    // Six beats returned: four are consumed, the two after the burst ends are ignored.
    task automatic test_single_read();
        model_beats = 6; model_base = 64'hA0;
        @(posedge clk); #1;
        rd_req = 1'b1; rd_addr = 21'h1ABCD;
        @(negedge clk);
        n_vec++; if (rd_ack !== 1'b1 || wr_ack !== 1'b0) begin n_bad++; $display("FAIL rd_ack: rd_ack=%b wr_ack=%b expected 1 0", rd_ack, wr_ack); end
        @(posedge clk); #1;
        rd_req = 1'b0;
        @(negedge clk);
        n_vec++; if (mem_cmd_en !== 1'b1 || mem_cmd !== 1'b0 || mem_addr !== 21'h1ABCD) begin n_bad++; $display("FAIL rd_cmd: en=%b cmd=%b addr=%h expected 1 0 1abcd", mem_cmd_en, mem_cmd, mem_addr); end
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i >= 2 && i <= 5) begin
                n_vec++; if (rd_valid !== 1'b1 || rd_data !== 64'hA0 + 64'(i - 2) || rd_beat_idx !== 2'(i - 2)) begin n_bad++; $display("FAIL rd_beat%0d: v=%b d=%h i=%0d expected 1 %h %0d", i - 2, rd_valid, rd_data, rd_beat_idx, 64'hA0 + 64'(i - 2), i - 2); end
            end else begin
                n_vec++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_idle_cyc%0d: rd_valid=%b expected 0", i, rd_valid); end
            end
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_timeout();
        int nv;
        int wait_cyc;
        nv = 0;
        model_beats = 2; model_base = 64'hB0;
        @(posedge clk); #1;
        rd_req = 1'b1; rd_addr = 21'h000055;
        @(negedge clk);
        n_vec++; if (rd_ack !== 1'b1) begin n_bad++; $display("FAIL to_ack: got %b expected 1", rd_ack); end
        @(posedge clk); #1;
        rd_req = 1'b0;
        @(negedge clk);
        n_vec++; if (mem_cmd_en !== 1'b1) begin n_bad++; $display("FAIL to_cmd_en: got %b expected 1", mem_cmd_en); end
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) nv++;
            if (i == 63) begin
                n_vec++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL to_early: err=%b at cyc 63 expected 0", err_timeout); end
            end
            if (i == 64) begin
                n_vec++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL to_set: err=%b at cyc 64 expected 1", err_timeout); end
            end
        end
        n_vec++; if (nv !== 2) begin n_bad++; $display("FAIL to_beats: got %0d rd_valid beats expected 2", nv); end
        @(posedge clk); #1;
        wr_req = 1'b1; wr_addr = 21'h000077;
        wait_cyc = 0;
        @(negedge clk);
        while (wr_ack !== 1'b1 && wait_cyc < 40) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_vec++; if (wr_ack !== 1'b1) begin n_bad++; $display("FAIL to_next_req: wr_ack=%b after %0d cycles expected 1", wr_ack, wait_cyc); end
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(negedge clk);
        n_vec++; if (mem_cmd_en !== 1'b1 || mem_addr !== 21'h000077) begin n_bad++; $display("FAIL to_next_cmd: en=%b addr=%h expected 1 000077", mem_cmd_en, mem_addr); end
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_vec++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b expected 1", err_timeout); end
    endtask

    task automatic test_alternate();
        logic g_kind [4];
        logic c_kind [4];
        int   c_cyc  [4];
        logic exp_kind [4];
        int   g_n;
        int   c_n;
        int   cyc;
        exp_kind[0] = 1'b0; exp_kind[1] = 1'b1; exp_kind[2] = 1'b0; exp_kind[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin g_kind[i] = 1'bx; c_kind[i] = 1'bx; c_cyc[i] = 0; end
        g_n = 0; c_n = 0; cyc = 0;
        @(posedge clk); #1;
        rst_n = 1'b0; init_calib = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL alt_err_cleared: got %b expected 0", err_timeout); end
        @(posedge clk); #1;
        rst_n = 1'b1; model_beats = 4; model_base = 64'hC0;
        wr_req = 1'b1; rd_req = 1'b1; wr_addr = 21'h000200; rd_addr = 21'h000100;
        while (c_n < 4 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (g_n < 4 && rd_ack === 1'b1) begin g_kind[g_n] = 1'b0; g_n++; end
            if (g_n < 4 && wr_ack === 1'b1) begin g_kind[g_n] = 1'b1; g_n++; end
            if (mem_cmd_en === 1'b1) begin c_kind[c_n] = mem_cmd; c_cyc[c_n] = cyc; c_n++; end
        end
        @(posedge clk); #1;
        wr_req = 1'b0; rd_req = 1'b0;
        n_vec++; if (c_n !== 4) begin n_bad++; $display("FAIL alt_count: got %0d commands in %0d cycles expected 4", c_n, cyc); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (g_kind[i] !== exp_kind[i]) begin n_bad++; $display("FAIL alt_grant%0d: got %b expected %b (0=R 1=W)", i, g_kind[i], exp_kind[i]); end
            n_vec++; if (c_kind[i] !== exp_kind[i]) begin n_bad++; $display("FAIL alt_cmd%0d: mem_cmd=%b expected %b", i, c_kind[i], exp_kind[i]); end
        end
        for (int i = 1; i < 4; i++) begin
            n_vec++; if (c_cyc[i] - c_cyc[i - 1] < 19) begin n_bad++; $display("FAIL alt_spacing%0d: got %0d cycles expected >= 19", i, c_cyc[i] - c_cyc[i - 1]); end
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset_midburst();
        int n_en;
        int n_ack;
        int n_beat;
        n_en = 0; n_ack = 0; n_beat = 0;
        @(posedge clk); #1;
        wr_req = 1'b1; wr_addr = 21'h000099; wr_data = 64'hD0; wr_mask = 8'h3C;
        @(negedge clk);
        n_vec++; if (wr_ack !== 1'b1) begin n_bad++; $display("FAIL mb_ack: got %b expected 1", wr_ack); end
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(negedge clk);
        n_vec++; if (wr_beat !== 1'b1) begin n_bad++; $display("FAIL mb_beat1: got %b expected 1", wr_beat); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++; if (wr_beat !== 1'b1 || mem_wr_data !== 64'hD0) begin n_bad++; $display("FAIL mb_beat3: beat=%b data=%h expected 1 d0", wr_beat, mem_wr_data); end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if (wr_beat !== 1'b0 || mem_data_mask !== 8'hFF || mem_wr_data !== 64'd0) begin n_bad++; $display("FAIL mb_abort: beat=%b mask=%h data=%h expected 0 ff 0", wr_beat, mem_data_mask, mem_wr_data); end
        n_vec++; if (mem_cmd !== 1'b0 || mem_addr !== 21'd0) begin n_bad++; $display("FAIL mb_cmd_clr: cmd=%b addr=%h expected 0 0", mem_cmd, mem_addr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_cmd_en === 1'b1) n_en++;
            if (wr_ack === 1'b1 || rd_ack === 1'b1) n_ack++;
            if (wr_beat === 1'b1) n_beat++;
        end
        n_vec++; if (n_en !== 0) begin n_bad++; $display("FAIL mb_no_cmd_en: got %0d pulses expected 0", n_en); end
        n_vec++; if (n_ack !== 0 || n_beat !== 0) begin n_bad++; $display("FAIL mb_quiet: acks=%0d beats=%0d expected 0 0", n_ack, n_beat); end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        model_beats = 4;
        model_base  = 64'd0;
        test_reset();
        test_init_gate();
        test_single_write();
        test_single_read();
        test_timeout();
        test_alternate();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
